// File: rtl/os_sched_pkg.sv
// Shared types and sizing helpers for the output-stationary array scheduler.
package os_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int JOB_CYC_W = 16;

    // Phase counter width: wide enough for the longest phase at the maximum job depth.
    function automatic int cnt_width(input int k_w, input int n, input int pe_lat);
        return k_w + $clog2(4 * n + pe_lat) + 1;
    endfunction

    // Operands skew across N lanes, so the last lane finishes N-1 cycles after the first.
    function automatic int feed_len(input int k, input int n);
        return k + n - 1;
    endfunction

    // Last products must cross the array diagonal and clear the PE pipeline.
    function automatic int flush_len(input int n, input int pe_lat);
        return 2 * (n - 1) + pe_lat;
    endfunction

    // Init sweep skew plus pipeline, then N result words per row.
    function automatic int drain_len(input int n, input int pe_lat);
        return (n - 1) + pe_lat + n;
    endfunction

endpackage

// File: rtl/os_skew_window.sv
// Per-lane window detector: win is high while base <= c < base + len and en is set.
module os_skew_window #(
    parameter int CW = 8
) (
    input  logic          en,
    input  logic [CW-1:0] c,
    input  logic [CW-1:0] base,
    input  logic [CW-1:0] len,
    output logic          win
);

    logic [CW:0] stop;

    // One extra bit keeps base + len from wrapping at the top of the counter range.
    assign stop = {1'b0, base} + {1'b0, len};
    assign win  = en && (c >= base) && ({1'b0, c} < stop);

endmodule

// File: rtl/os_array_scheduler.sv
// Job sequencer for an N x N output-stationary systolic array: skewed feeds,
// flush, zero-operand init sweep that dumps results, then a done pulse.
module os_array_scheduler
    import os_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int PE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic [N-1:0]         feed_row_en,
    output logic [N-1:0]         feed_col_en,
    output logic [N-1:0]         init_row,
    output logic [N-1:0]         res_valid,
    output logic [$clog2(N)-1:0] res_idx,
    output logic                 done,
    output logic                 err_klen,
    output logic [15:0]          job_cycles
);

    localparam int IW = $clog2(N);
    localparam int CW = cnt_width(K_W, N, PE_LAT);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(flush_len(N, PE_LAT) - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N, PE_LAT) - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        c_q, c_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [JOB_CYC_W-1:0] cyc_q, cyc_d;
    logic [JOB_CYC_W-1:0] job_cycles_q, job_cycles_d;
    logic                 err_d;
    logic [CW-1:0]        feed_last;

    logic                 ready_q, busy_q, done_q, err_klen_q;
    logic [N-1:0]         row_q, col_q, init_q, valid_q;
    logic [IW-1:0]        idx_q, idx_d;

    logic [N-1:0]         row_win, col_win, init_win, valid_win;
    logic                 feed_en, init_en, drain_en;

    assign feed_last = CW'(k_q) + CW'(N - 2);

    // Next-state logic: phase sequencing, job acceptance and abort.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d = FEED;
                        k_d     = k_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (abort)                  state_d = IDLE;
                else if (c_q == feed_last)  state_d = FLUSH;
            end
            FLUSH: begin
                if (abort)                  state_d = IDLE;
                else if (c_q == FLUSH_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                  state_d = IDLE;
                else if (c_q == DRAIN_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state change; busy-cycle counter saturates.
    always_comb begin
        c_d          = c_q + CW'(1);
        cyc_d        = (cyc_q == '1) ? cyc_q : cyc_q + JOB_CYC_W'(1);
        job_cycles_d = job_cycles_q;
        if (state_d == IDLE || state_d != state_q) c_d = '0;
        if (state_d == IDLE) cyc_d = '0;
        if (state_d == DONE) job_cycles_d = cyc_d;
    end

    // Lane windows are evaluated on the next state so the outputs line up with it.
    assign feed_en  = (state_d == FEED);
    assign init_en  = (state_d == FEED) || (state_d == DRAIN);
    assign drain_en = (state_d == DRAIN);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            os_skew_window #(.CW(CW)) u_row (
                .en(feed_en), .c(c_d), .base(CW'(gi)), .len(CW'(k_d)), .win(row_win[gi])
            );
            os_skew_window #(.CW(CW)) u_col (
                .en(feed_en), .c(c_d), .base(CW'(gi)), .len(CW'(k_d)), .win(col_win[gi])
            );
            os_skew_window #(.CW(CW)) u_init (
                .en(init_en), .c(c_d), .base(CW'(gi)), .len(CW'(1)), .win(init_win[gi])
            );
            os_skew_window #(.CW(CW)) u_valid (
                .en(drain_en), .c(c_d), .base(CW'(gi + PE_LAT)), .len(CW'(N)), .win(valid_win[gi])
            );
        end
    endgenerate

    // Result index follows the lowest row whose result window is open.
    always_comb begin
        idx_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_win[i]) idx_d = IW'(N - 1 - (int'(c_d) - i - PE_LAT));
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            c_q          <= '0;
            k_q          <= '0;
            cyc_q        <= '0;
            job_cycles_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_klen_q   <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            init_q       <= '0;
            valid_q      <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            k_q          <= k_d;
            cyc_q        <= cyc_d;
            job_cycles_q <= job_cycles_d;
            ready_q      <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            err_klen_q   <= err_d;
            row_q        <= row_win;
            col_q        <= col_win;
            init_q       <= init_win;
            valid_q      <= valid_win;
            idx_q        <= idx_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_klen    = err_klen_q;
    assign feed_row_en = row_q;
    assign feed_col_en = col_q;
    assign init_row    = init_q;
    assign res_valid   = valid_q;
    assign res_idx     = idx_q;
    assign job_cycles  = job_cycles_q;

endmodule

// File: tb/tb_os_array_scheduler.sv
// Self-checking bench for os_array_scheduler: table-driven jobs, randomized jobs
// against a cycle-indexed reference model, and hand-written corner sequences.
module tb_os_array_scheduler;

    localparam int N   = 4;
    localparam int KW  = 8;
    localparam int P   = 2;
    localparam int IW  = $clog2(N);
    localparam int NB  = 16;
    localparam int IWB = $clog2(NB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort;
    logic [KW-1:0] k_len;
    logic          ready, busy, done, err_klen;
    logic [N-1:0]  feed_row_en, feed_col_en, init_row, res_valid;
    logic [IW-1:0] res_idx;
    logic [15:0]   job_cycles;

    logic           start_b, abort_b;
    logic [KW-1:0]  k_len_b;
    logic           ready_b, busy_b, done_b, err_klen_b;
    logic [NB-1:0]  row_b, col_b, init_b, valid_b;
    logic [IWB-1:0] idx_b;
    logic [15:0]    job_cycles_b;

    os_array_scheduler #(.N(N), .K_W(KW), .PE_LAT(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
        .ready(ready), .busy(busy), .feed_row_en(feed_row_en), .feed_col_en(feed_col_en),
        .init_row(init_row), .res_valid(res_valid), .res_idx(res_idx), .done(done),
        .err_klen(err_klen), .job_cycles(job_cycles)
    );

    os_array_scheduler #(.N(NB), .K_W(KW), .PE_LAT(P)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .k_len(k_len_b), .abort(abort_b),
        .ready(ready_b), .busy(busy_b), .feed_row_en(row_b), .feed_col_en(col_b),
        .init_row(init_b), .res_valid(valid_b), .res_idx(idx_b), .done(done_b),
        .err_klen(err_klen_b), .job_cycles(job_cycles_b)
    );

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic [N-1:0]  frow;
        logic [N-1:0]  fcol;
        logic [N-1:0]  init;
        logic [N-1:0]  rv;
        logic [IW-1:0] ridx;
        logic          done;
    } obs_t;

    typedef struct {
        int k;
        int exp_busy;
        int exp_done;
        int exp_err;
        int exp_jc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int total_busy(input int k);
        return (k + N - 1) + (2 * N - 2 + P) + (2 * N - 1 + P) + 1;
    endfunction

    // Expected outputs on busy cycle t of a depth-k job (t outside the job = idle).
    function automatic obs_t model(input int k, input int t);
        obs_t o;
        int   f, l, d, c;
        bit   found;
        o = '0;
        f = k + N - 1;
        l = 2 * N - 2 + P;
        d = 2 * N - 1 + P;
        found = 1'b0;
        if (t < 0 || t >= f + l + d + 1) begin
            o.ready = 1'b1;
            return o;
        end
        o.busy = 1'b1;
        if (t < f) begin
            c = t;
            for (int i = 0; i < N; i++) begin
                o.frow[i] = (c >= i) && (c < i + k);
                o.fcol[i] = (c >= i) && (c < i + k);
                o.init[i] = (c == i);
            end
        end else if (t >= f + l && t < f + l + d) begin
            c = t - f - l;
            for (int i = 0; i < N; i++) begin
                o.init[i] = (c == i);
                if (c >= i + P && c < i + P + N) begin
                    o.rv[i] = 1'b1;
                    if (!found) o.ridx = IW'(N - 1 - (c - i - P));
                    found = 1'b1;
                end
            end
        end else if (t == f + l + d) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ready = ready;
        o.busy  = busy;
        o.frow  = feed_row_en;
        o.fcol  = feed_col_en;
        o.init  = init_row;
        o.rv    = res_valid;
        o.ridx  = res_idx;
        o.done  = done;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one job and follow it until busy drops (or abort_t is reached).
    task automatic run_job(input int k, input bit hold, input int abort_t, input bit wave,
                           output int busy_n, output int done_n, output int err_n);
        int t;
        start = 1'b1;
        k_len = KW'(k);
        step();
        if (!hold) start = 1'b0;
        busy_n = 0;
        done_n = 0;
        err_n  = int'(err_klen);
        t = 0;
        while (busy && t < 2000) begin
            if (wave) chk($sformatf("wave k=%0d t=%0d", k, t), 64'(sample()), 64'(model(k, t)));
            busy_n++;
            done_n += int'(done);
            if (t == abort_t) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                return;
            end
            step();
            t++;
        end
        chk("job_end_busy", 64'(busy), 64'(0));
        if (wave) chk($sformatf("idle_after k=%0d", k), 64'(sample()), 64'(model(k, t)));
    endtask

    initial begin
        vec_t vecs[5];
        int   b, d, e, k, last_jc, fcnt;

        vecs[0] = '{k: 1,   exp_busy: 22,  exp_done: 1, exp_err: 0, exp_jc: 22};
        vecs[1] = '{k: 0,   exp_busy: 0,   exp_done: 0, exp_err: 1, exp_jc: 22};
        vecs[2] = '{k: 7,   exp_busy: 28,  exp_done: 1, exp_err: 0, exp_jc: 28};
        vecs[3] = '{k: 255, exp_busy: 276, exp_done: 1, exp_err: 0, exp_jc: 276};
        vecs[4] = '{k: 2,   exp_busy: 23,  exp_done: 1, exp_err: 0, exp_jc: 23};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0;
        start_b = 1'b0; abort_b = 1'b0; k_len_b = '0;
        #12;
        chk("reset_outputs", 64'(sample()), 64'(model(0, -1)));
        chk("reset_job_cycles", 64'(job_cycles), 64'(0));
        chk("reset_err_klen", 64'(err_klen), 64'(0));
        #11 rst_n = 1'b1;
        step();
        chk("post_reset_idle", 64'(sample()), 64'(model(0, -1)));

        // Reference job K=3: full waveform, 24 busy cycles, one done.
        run_job(3, 1'b0, -1, 1'b1, b, d, e);
        $display("job k=3 busy=%0d done=%0d job_cycles=%0d", b, d, job_cycles);
        chk("k3_busy", 64'(b), 64'(24));
        chk("k3_done", 64'(d), 64'(1));
        chk("k3_job_cycles", 64'(job_cycles), 64'(24));

        // Table-driven jobs, including k_len=0 and the maximum depth.
        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].k, 1'b0, -1, vecs[v].k != 0, b, d, e);
            $display("job k=%0d busy=%0d done=%0d err=%0d job_cycles=%0d",
                     vecs[v].k, b, d, e, job_cycles);
            chk($sformatf("tbl%0d_busy", v), 64'(b), 64'(vecs[v].exp_busy));
            chk($sformatf("tbl%0d_done", v), 64'(d), 64'(vecs[v].exp_done));
            chk($sformatf("tbl%0d_err", v), 64'(e), 64'(vecs[v].exp_err));
            chk($sformatf("tbl%0d_jc", v), 64'(job_cycles), 64'(vecs[v].exp_jc));
            chk($sformatf("tbl%0d_ready", v), 64'(ready), 64'(1));
            step();
            chk($sformatf("tbl%0d_err_clear", v), 64'(err_klen), 64'(0));
        end
        last_jc = 23;

        // Randomized depths checked cycle by cycle against the model.
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 40);
            run_job(k, 1'b0, -1, 1'b1, b, d, e);
            $display("job k=%0d busy=%0d done=%0d job_cycles=%0d", k, b, d, job_cycles);
            chk($sformatf("rnd%0d_jc", r), 64'(job_cycles), 64'(total_busy(k)));
            last_jc = total_busy(k);
        end

        // Abort in FLUSH at c=3 (busy cycle 6+3).
        run_job(3, 1'b0, 9, 1'b1, b, d, e);
        $display("job k=3 aborted in FLUSH busy=%0d done=%0d", b, d);
        chk("abort_flush_idle", 64'(sample()), 64'(model(3, -1)));
        chk("abort_flush_done", 64'(d), 64'(0));
        chk("abort_flush_jc", 64'(job_cycles), 64'(last_jc));

        // Abort at a random point inside DRAIN.
        k = $urandom_range(1, 10);
        run_job(k, 1'b0, (k + N - 1) + (2 * N - 2 + P) + $urandom_range(0, 2 * N - 2 + P),
                1'b1, b, d, e);
        $display("job k=%0d aborted in DRAIN busy=%0d done=%0d", k, b, d);
        chk("abort_drain_idle", 64'(sample()), 64'(model(k, -1)));
        chk("abort_drain_jc", 64'(job_cycles), 64'(last_jc));

        // Start held high with K=1: back-to-back jobs, one IDLE cycle between.
        run_job(1, 1'b1, -1, 1'b1, b, d, e);
        $display("job k=1 held-start #1 busy=%0d done=%0d", b, d);
        run_job(1, 1'b1, -1, 1'b1, b, d, e);
        start = 1'b0;
        $display("job k=1 held-start #2 busy=%0d done=%0d", b, d);
        chk("b2b_done", 64'(d), 64'(1));
        chk("b2b_jc", 64'(job_cycles), 64'(22));

        // Asynchronous reset in the middle of DRAIN.
        start = 1'b1; k_len = 8'd3;
        step();
        start = 1'b0;
        repeat (18) step();
        chk("pre_reset_drain", 64'(sample()), 64'(model(3, 18)));
        #2 rst_n = 1'b0;
        #1;
        $display("job k=3 async reset in DRAIN");
        chk("async_reset_outputs", 64'(sample()), 64'(model(3, -1)));
        chk("async_reset_jc", 64'(job_cycles), 64'(0));
        #3 rst_n = 1'b1;
        step();
        run_job(3, 1'b0, -1, 1'b1, b, d, e);
        $display("job k=3 after reset busy=%0d done=%0d job_cycles=%0d", b, d, job_cycles);
        chk("after_reset_jc", 64'(job_cycles), 64'(24));

        // N=16, K=255: no counter wrap.
        start_b = 1'b1; k_len_b = 8'd255;
        step();
        start_b = 1'b0;
        b = 0; d = 0; fcnt = 0;
        while (busy_b && b < 2000) begin
            b++;
            d += int'(done_b);
            if (row_b != '0) fcnt++;
            step();
        end
        $display("job N=16 k=255 busy=%0d feed=%0d done=%0d job_cycles=%0d", b, fcnt, d, job_cycles_b);
        chk("big_busy", 64'(b), 64'(336));
        chk("big_feed", 64'(fcnt), 64'(270));
        chk("big_done", 64'(d), 64'(1));
        chk("big_jc", 64'(job_cycles_b), 64'(336));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
